// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - Kyber arithmetic constants, coefficient type and mod-q helpers
// Optional macro BF_HALVE_EN adds the mod-q halving helper.
package kyber_pkg;

  localparam int KYBER_Q = 3329;
  localparam int COEF_W  = 12;
  localparam int KYBER_N = 256;

  typedef logic [COEF_W-1:0] coef_t;

  // q at one bit wider than a coefficient, for comparing raw sums/differences
  localparam logic [COEF_W:0] Q_WIDE = (COEF_W+1)'(KYBER_Q);
  localparam coef_t           Q_COEF = COEF_W'(KYBER_Q);

  // Map v in [0, 2q) to [0, q). When v >= q the true result is below 2^COEF_W,
  // so subtracting in COEF_W bits from the low bits gives the exact answer.
  function automatic coef_t cond_sub_q(input logic [COEF_W:0] v);
    coef_t res;
    if (v >= Q_WIDE) begin
      res = v[COEF_W-1:0] - Q_COEF;
    end else begin
      res = v[COEF_W-1:0];
    end
    return res;
  endfunction

`ifdef BF_HALVE_EN
  // (q + 1) / 2: for odd v, (v + q) >> 1 equals (v >> 1) + (q + 1) / 2
  localparam coef_t HALF_Q = COEF_W'((KYBER_Q + 1) / 2);

  // Multiply by 2^-1 mod q without a wide adder.
  function automatic coef_t halve_q(input coef_t v);
    coef_t res;
    res = {1'b0, v[COEF_W-1:1]} + (v[0] ? HALF_Q : '0);
    return res;
  endfunction
`endif

endpackage

// File: rtl/ntt_delay_line.sv
// rtl/ntt_delay_line.sv - en-gated WIDTH x DEPTH shift register with async active-low clear
module ntt_delay_line #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Shift one slot per advancing cycle; clear wipes every slot so no stale beat survives reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (en_i) begin
      mem_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign q_o = mem_q[DEPTH-1];

endmodule

// File: rtl/ntt_bf_addsub.sv
// rtl/ntt_bf_addsub.sv - Kyber NTT butterfly add/sub half: x=(a+t) mod q, y=(a-t) mod q
// Optional macro BF_HALVE_EN: halve both results mod q (inverse-NTT Gentleman-Sande use).
module ntt_bf_addsub
  import kyber_pkg::*;
#(
  parameter int RED_LAT = 4,
  parameter int N       = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        in_valid,
  input  logic [11:0] a_in,
  input  logic [11:0] t_in,
  output logic        out_valid,
  output logic [11:0] x_out,
  output logic [11:0] y_out,
  output logic        out_last,
  output logic [7:0]  out_idx
);

  localparam logic [7:0] IDX_LAST = 8'(N - 1);

  // ---------------------------------------------------------------------------
  // Alignment: {in_valid, a_in} travels RED_LAT advancing cycles so it meets
  // the reducer output t_in belonging to the same beat.
  // ---------------------------------------------------------------------------
  logic [COEF_W:0] align_d;
  logic [COEF_W:0] align_q;
  logic            a_valid;
  coef_t           a_dly;

  assign align_d = {in_valid, a_in};

  ntt_delay_line #(
    .WIDTH(COEF_W + 1),
    .DEPTH(RED_LAT)
  ) u_align (
    .clk_i (clk),
    .rst_ni(rst_n),
    .en_i  (en),
    .d_i   (align_d),
    .q_o   (align_q)
  );

  assign {a_valid, a_dly} = align_q;

  // ---------------------------------------------------------------------------
  // Stage A: raw sum and q-biased difference, both in [0, 2q) for legal inputs
  // ---------------------------------------------------------------------------
  logic [COEF_W:0] s_d;
  logic [COEF_W:0] r_d;
  logic [COEF_W:0] s_q;
  logic [COEF_W:0] r_q;
  logic            va_q;

  // Biasing the difference by q keeps it non-negative, so one conditional subtract suffices later
  always_comb begin
    s_d = {1'b0, a_dly} + {1'b0, t_in};
    r_d = {1'b0, a_dly} + Q_WIDE - {1'b0, t_in};
  end

  // Stage A register; bubbles shift through with valid low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q  <= '0;
      r_q  <= '0;
      va_q <= 1'b0;
    end else if (en) begin
      s_q  <= s_d;
      r_q  <= r_d;
      va_q <= a_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage B: reduce to [0, q), optionally halve, and index the beat
  // ---------------------------------------------------------------------------
  coef_t      x_d;
  coef_t      y_d;
  logic [7:0] cnt_d;
  logic       last_d;

  coef_t      x_q;
  coef_t      y_q;
  logic       valid_q;
  logic       last_q;
  logic [7:0] idx_q;
  logic [7:0] cnt_q;

  // Final reduction plus polynomial-position bookkeeping for the beat in stage A
  always_comb begin
`ifdef BF_HALVE_EN
    x_d = halve_q(cond_sub_q(s_q));
    y_d = halve_q(cond_sub_q(r_q));
`else
    x_d = cond_sub_q(s_q);
    y_d = cond_sub_q(r_q);
`endif
    last_d = va_q && (cnt_q == IDX_LAST);
    cnt_d  = (cnt_q == IDX_LAST) ? 8'd0 : cnt_q + 8'd1;
  end

  // Output register: results and index only move on valid beats, so bubbles leave them held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else if (en) begin
      valid_q <= va_q;
      last_q  <= last_d;
      if (va_q) begin
        x_q   <= x_d;
        y_q   <= y_d;
        idx_q <= cnt_q;
        cnt_q <= cnt_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign out_idx   = idx_q;

endmodule

// File: tb/tb_ntt_bf_addsub.sv
// tb/tb_ntt_bf_addsub.sv - self-checking bench for ntt_bf_addsub against a modular-arithmetic model
module tb_ntt_bf_addsub;

  localparam int RED_LAT = 4;
  localparam int N       = 256;
  localparam int Q       = 3329;
  localparam int HMAX    = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic [11:0] a_in;
  logic [11:0] t_in;
  logic        out_valid;
  logic [11:0] x_out;
  logic [11:0] y_out;
  logic        out_last;
  logic [7:0]  out_idx;

  int tests = 0;
  int fails = 0;

  // Per-advancing-cycle history since the last reset
  int k      = 0;
  int vcount = 0;
  bit hv   [HMAX];
  int ha   [HMAX];
  int ht   [HMAX];
  int hidx [HMAX];
  bit hlit [HMAX];
  int hlx  [HMAX];
  int hly  [HMAX];

  int lastv   = 0;
  int lastx   = 0;
  int lasty   = 0;
  int lastidx = 0;
  int nlast   = 0;

  ntt_bf_addsub #(
    .RED_LAT(RED_LAT),
    .N      (N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_valid (in_valid),
    .a_in     (a_in),
    .t_in     (t_in),
    .out_valid(out_valid),
    .x_out    (x_out),
    .y_out    (y_out),
    .out_last (out_last),
    .out_idx  (out_idx)
  );

  always #5 clk = ~clk;

  function automatic int half_mod(input int v);
`ifdef BF_HALVE_EN
    return (v * ((Q + 1) / 2)) % Q;
`else
    return v;
`endif
  endfunction

  function automatic int ref_x(input int a, input int t);
    return half_mod((a + t) % Q);
  endfunction

  function automatic int ref_y(input int a, input int t);
    return half_mod((a - t + Q) % Q);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare outputs after advancing cycle kk against the beat that entered RED_LAT+2 cycles earlier
  task automatic check_out(input int kk);
    int j;
    int ex;
    int ey;
    j = kk - RED_LAT - 1;
    if (j >= 0 && hv[j]) begin
      ex = ref_x(ha[j], ht[j]);
      ey = ref_y(ha[j], ht[j]);
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("x_out", 32'(x_out), 32'(ex));
      chk("y_out", 32'(y_out), 32'(ey));
      chk("out_idx", 32'(out_idx), 32'(hidx[j]));
      chk("out_last", 32'(out_last), 32'(hidx[j] == N - 1));
      if (hlit[j]) begin
        chk("x_directed", 32'(x_out), 32'(hlx[j]));
        chk("y_directed", 32'(y_out), 32'(hly[j]));
      end
      lastv   = 1;
      lastx   = ex;
      lasty   = ey;
      lastidx = hidx[j];
    end else begin
      chk("bubble_valid", 32'(out_valid), 32'd0);
      chk("bubble_x_hold", 32'(x_out), 32'(lastx));
      chk("bubble_y_hold", 32'(y_out), 32'(lasty));
      chk("bubble_idx_hold", 32'(out_idx), 32'(lastidx));
      lastv = 0;
    end
    if (out_valid === 1'b1 && out_last === 1'b1) nlast++;
  endtask

  // One advancing cycle; the reducer model supplies t of the beat issued RED_LAT cycles ago
  task automatic step(input bit v, input int a, input int t, input bit lit, input int lx, input int ly);
    if (k >= HMAX) begin
      $display("FAIL history_overflow: observed %0d expected below %0d", k, HMAX);
      $fatal(1);
    end
    hv[k]   = v;
    ha[k]   = a;
    ht[k]   = t;
    hlit[k] = lit;
    hlx[k]  = lx;
    hly[k]  = ly;
    hidx[k] = vcount % N;
    if (v) vcount++;
    en       = 1'b1;
    in_valid = v;
    a_in     = 12'(a);
    t_in     = (k >= RED_LAT) ? 12'(ht[k - RED_LAT]) : 12'd0;
    @(negedge clk);
    check_out(k);
    k++;
  endtask

  task automatic rnd_beat(input bit v);
    step(v, int'($urandom_range(0, Q - 1)), int'($urandom_range(0, Q - 1)), 1'b0, 0, 0);
  endtask

  // Hold en low with garbage on the inputs; every output must stay frozen
  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      en       = 1'b0;
      in_valid = 1'($urandom);
      a_in     = 12'($urandom);
      t_in     = 12'($urandom);
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'(lastv));
      chk("stall_x", 32'(x_out), 32'(lastx));
      chk("stall_y", 32'(y_out), 32'(lasty));
      chk("stall_idx", 32'(out_idx), 32'(lastidx));
    end
  endtask

  task automatic model_reset();
    k       = 0;
    vcount  = 0;
    lastv   = 0;
    lastx   = 0;
    lasty   = 0;
    lastidx = 0;
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    in_valid = 1'b0;
    a_in     = '0;
    t_in     = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_x", 32'(x_out), 32'd0);
    chk("rst_y", 32'(y_out), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    rst_n = 1'b1;
    model_reset();

    // Directed vectors, back to back
`ifdef BF_HALVE_EN
    step(1'b1, 1, 0, 1'b1, 1665, 1665);
    step(1'b1, 4, 2, 1'b1, 3, 1);
`else
    step(1'b1, 100, 200, 1'b1, 300, 3229);
    step(1'b1, 3000, 1000, 1'b1, 671, 2000);
    step(1'b1, 3328, 3328, 1'b1, 3327, 0);
    step(1'b1, 0, 0, 1'b1, 0, 0);
`endif
    // Random beats with occasional bubbles
    for (int i = 0; i < 40; i++) rnd_beat(($urandom_range(0, 3) != 0));
    for (int i = 0; i < RED_LAT + 3; i++) rnd_beat(1'b0);

    // Four beats in flight, then asynchronous reset between clock edges
    for (int i = 0; i < 4; i++) rnd_beat(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_x", 32'(x_out), 32'd0);
    chk("async_rst_y", 32'(y_out), 32'd0);
    chk("async_rst_last", 32'(out_last), 32'd0);
    chk("async_rst_idx", 32'(out_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // No stale beat may emerge after release
    for (int i = 0; i < RED_LAT + 4; i++) rnd_beat(1'b0);

    // A full polynomial plus two beats, with 3 bubbles and a 5-cycle stall mid-stream
    nlast = 0;
    for (int p = 0; p < N + 2; p++) begin
      if (p == 50 || p == 121 || p == 202) rnd_beat(1'b0);
      if (p == 150) stall(5);
      rnd_beat(1'b1);
    end
    for (int i = 0; i < RED_LAT + 3; i++) rnd_beat(1'b0);
    chk("last_pulses", 32'(nlast), 32'd1);
    chk("beat257_idx", 32'(lastidx), 32'(out_idx));
    chk("beat257_idx_value", 32'(out_idx), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
